// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding, default operand width and iteration-counter width.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

    // Counter width for an arbitrary operand width (at least one bit).
    function automatic int mul_cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: radix-2 shift-add multiplier, one multiplier bit per cycle.
// Latency is WIDTH+1 cycles from the Start-sampling edge to the Done cycle.
// Optional macro MUL_SIGNED_EN: when defined, Signed=1 multiplies operand
// magnitudes and negates the product when the operand signs differ; when
// undefined, Signed is accepted but ignored and every operation is unsigned.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Long,
    input  logic             Signed,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic             WE4w
);

    localparam int            CW       = mul_cnt_width(WIDTH);
    localparam int            PW       = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mul_state_e      state;
    mul_state_e      state_nxt;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW:0]     acc;
    logic [PW:0]     acc_sum;
    logic [PW-1:0]   final_prod;
    logic            long_q;
    logic            neg_q;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic            neg_d;

    // Two's-complement negation of the full-width product.
    function automatic logic [PW-1:0] negate_prod(input logic [PW-1:0] v);
        return ~v + 1'b1;
    endfunction

`ifdef MUL_SIGNED_EN
    // Magnitude of a possibly-signed operand; the most negative value maps
    // to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    assign mag_a = magnitude(SrcA, Signed);
    assign mag_b = magnitude(SrcB, Signed);
    assign neg_d = Signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
`else
    logic signed_unused;
    assign signed_unused = Signed;
    assign mag_a         = SrcA;
    assign mag_b         = SrcB;
    assign neg_d         = 1'b0;
`endif

    // Partial-product addition for the current multiplier bit; the extra
    // accumulator bit keeps the carry out of the top product bit.
    assign acc_sum    = acc + (mplier[0] ? {1'b0, mcand} : '0);
    assign final_prod = neg_q ? negate_prod(acc_sum[PW-1:0]) : acc_sum[PW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        WE4w      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                WE4w      = long_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control and result registers: iteration count, captured mode bits and
    // the product words, which change only when the last bit is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            long_q   <= 1'b0;
            neg_q    <= 1'b0;
            ResultLo <= '0;
            ResultHi <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        cnt    <= '0;
                        long_q <= Long;
                        neg_q  <= neg_d;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        {ResultHi, ResultLo} <= final_prod;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Shift-add datapath: multiplicand moves left, multiplier moves right.
    always_ff @(posedge clk) begin
        if (state == IDLE && Start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer (WIDTH = 32).
module tb_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        Start;
    logic        Long;
    logic        Signed;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] ResultLo;
    logic [31:0] ResultHi;
    logic        WE4w;

    int nchk;
    int nfail;
    int cycle_ctr;

    mul_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .Long     (Long),
        .Signed   (Signed),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .Busy     (Busy),
        .Done     (Done),
        .ResultLo (ResultLo),
        .ResultHi (ResultHi),
        .WE4w     (WE4w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle_ctr = 0;
    always @(posedge clk) cycle_ctr <= cycle_ctr + 1;

    // Present operands with Start for exactly one sampling edge; returns in RUN cycle 1.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic lng, input logic sgn);
        SrcA   = a;
        SrcB   = b;
        Long   = lng;
        Signed = sgn;
        Start  = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    // Advance until Done, bounded; cyc is the cycle number relative to Start.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (Done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        Start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        nchk++; if (Busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        nchk++; if (Done !== 1'b0) begin nfail++; $display("FAIL reset_done: got %b expected 0", Done); end
        nchk++; if (WE4w !== 1'b0) begin nfail++; $display("FAIL reset_we4w: got %b expected 0", WE4w); end
        nchk++; if (ResultLo !== 32'h0) begin nfail++; $display("FAIL reset_lo: got %h expected 0", ResultLo); end
        nchk++; if (ResultHi !== 32'h0) begin nfail++; $display("FAIL reset_hi: got %h expected 0", ResultHi); end
        reset = 1'b0;
        Start = 1'b0;
        @(posedge clk);
        #1;
        nchk++; if (Busy !== 1'b0) begin nfail++; $display("FAIL reset_start_discard: got busy %b expected 0", Busy); end
    endtask

    task automatic test_basic;
        int cyc;
        issue(32'd7, 32'd6, 1'b0, 1'b0);
        nchk++; if (Busy !== 1'b1) begin nfail++; $display("FAIL basic_busy_run: got %b expected 1", Busy); end
        wait_done(cyc);
        nchk++; if (cyc !== 33) begin nfail++; $display("FAIL basic_latency: got %0d expected 33", cyc); end
        nchk++; if (ResultLo !== 32'd42) begin nfail++; $display("FAIL basic_lo: got %h expected %h", ResultLo, 32'd42); end
        nchk++; if (ResultHi !== 32'd0) begin nfail++; $display("FAIL basic_hi: got %h expected 0", ResultHi); end
        nchk++; if (WE4w !== 1'b0) begin nfail++; $display("FAIL basic_we4w: got %b expected 0", WE4w); end
        nchk++; if (Busy !== 1'b1) begin nfail++; $display("FAIL basic_busy_done: got %b expected 1", Busy); end
        @(posedge clk);
        #1;
        nchk++; if (Done !== 1'b0) begin nfail++; $display("FAIL basic_done_pulse: got %b expected 0", Done); end
        nchk++; if (Busy !== 1'b0) begin nfail++; $display("FAIL basic_idle_busy: got %b expected 0", Busy); end
        nchk++; if (ResultLo !== 32'd42) begin nfail++; $display("FAIL basic_hold: got %h expected %h", ResultLo, 32'd42); end
    endtask

    task automatic test_ignore_start;
        int cyc;
        int ndone;
        int first;
        logic [31:0] lo_at;
        ndone = 0;
        first = 0;
        lo_at = '0;
        issue(32'd5, 32'd9, 1'b0, 1'b0);
        cyc = 1;
        while (cyc <= 70) begin
            if (cyc == 10) begin
                Start = 1'b1;
                SrcA  = 32'd100;
                SrcB  = 32'd100;
            end
            if (cyc == 11) Start = 1'b0;
            if (cyc == 20) begin
                nchk++; if (ResultLo !== 32'd42) begin nfail++; $display("FAIL ignore_run_hold: got %h expected %h", ResultLo, 32'd42); end
            end
            if (Done === 1'b1) begin
                ndone++;
                if (first == 0) begin
                    first = cyc;
                    lo_at = ResultLo;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        nchk++; if (first !== 33) begin nfail++; $display("FAIL ignore_latency: got %0d expected 33", first); end
        nchk++; if (lo_at !== 32'd45) begin nfail++; $display("FAIL ignore_lo: got %h expected %h", lo_at, 32'd45); end
        nchk++; if (ndone !== 1) begin nfail++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    endtask

    task automatic test_long;
        int cyc;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done(cyc);
        nchk++; if (cyc !== 33) begin nfail++; $display("FAIL long_latency: got %0d expected 33", cyc); end
        nchk++; if (ResultHi !== 32'hFFFF_FFFE) begin nfail++; $display("FAIL long_hi: got %h expected fffffffe", ResultHi); end
        nchk++; if (ResultLo !== 32'h0000_0001) begin nfail++; $display("FAIL long_lo: got %h expected 00000001", ResultLo); end
        nchk++; if (WE4w !== 1'b1) begin nfail++; $display("FAIL long_we4w: got %b expected 1", WE4w); end
        @(posedge clk);
        #1;
        nchk++; if (WE4w !== 1'b0) begin nfail++; $display("FAIL long_we4w_pulse: got %b expected 0", WE4w); end
        nchk++; if (ResultHi !== 32'hFFFF_FFFE) begin nfail++; $display("FAIL long_hold: got %h expected fffffffe", ResultHi); end
    endtask

    task automatic test_short_hiword;
        int cyc;
        issue(32'h0001_0000, 32'h0003_0000, 1'b0, 1'b0);
        wait_done(cyc);
        nchk++; if (ResultHi !== 32'd3) begin nfail++; $display("FAIL short_hi: got %h expected 3", ResultHi); end
        nchk++; if (ResultLo !== 32'd0) begin nfail++; $display("FAIL short_lo: got %h expected 0", ResultLo); end
        nchk++; if (WE4w !== 1'b0) begin nfail++; $display("FAIL short_we4w: got %b expected 0", WE4w); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero;
        int cyc;
        issue(32'd0, 32'h1234_5678, 1'b1, 1'b0);
        wait_done(cyc);
        nchk++; if (cyc !== 33) begin nfail++; $display("FAIL zero_latency: got %0d expected 33", cyc); end
        nchk++; if (ResultLo !== 32'd0) begin nfail++; $display("FAIL zero_lo: got %h expected 0", ResultLo); end
        nchk++; if (ResultHi !== 32'd0) begin nfail++; $display("FAIL zero_hi: got %h expected 0", ResultHi); end
        nchk++; if (WE4w !== 1'b1) begin nfail++; $display("FAIL zero_we4w: got %b expected 1", WE4w); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed;
        int cyc;
        logic [31:0] exp_hi;
`ifdef MUL_SIGNED_EN
        exp_hi = 32'hFFFF_FFFF;
`else
        exp_hi = 32'h0000_0002;
`endif
        issue(32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 1'b1);
        wait_done(cyc);
        nchk++; if (ResultHi !== exp_hi) begin nfail++; $display("FAIL signed_m1x3_hi: got %h expected %h", ResultHi, exp_hi); end
        nchk++; if (ResultLo !== 32'hFFFF_FFFD) begin nfail++; $display("FAIL signed_m1x3_lo: got %h expected fffffffd", ResultLo); end
        @(posedge clk);
        #1;
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        wait_done(cyc);
        nchk++; if (ResultHi !== 32'h4000_0000) begin nfail++; $display("FAIL signed_min_hi: got %h expected 40000000", ResultHi); end
        nchk++; if (ResultLo !== 32'h0) begin nfail++; $display("FAIL signed_min_lo: got %h expected 0", ResultLo); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        int nhigh;
        issue(32'd11, 32'd13, 1'b1, 1'b0);
        cyc = 1;
        while (cyc < 15) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        nchk++; if (Busy !== 1'b0) begin nfail++; $display("FAIL midrst_busy: got %b expected 0", Busy); end
        nchk++; if (ResultLo !== 32'h0) begin nfail++; $display("FAIL midrst_lo: got %h expected 0", ResultLo); end
        nchk++; if (ResultHi !== 32'h0) begin nfail++; $display("FAIL midrst_hi: got %h expected 0", ResultHi); end
        nhigh = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done !== 1'b0 || WE4w !== 1'b0) nhigh++;
            @(posedge clk);
            #1;
        end
        nchk++; if (nhigh !== 0) begin nfail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", nhigh); end
        issue(32'd11, 32'd13, 1'b1, 1'b0);
        wait_done(cyc);
        nchk++; if (cyc !== 33) begin nfail++; $display("FAIL midrst_fresh_latency: got %0d expected 33", cyc); end
        nchk++; if (ResultLo !== 32'd143) begin nfail++; $display("FAIL midrst_fresh_lo: got %h expected %h", ResultLo, 32'd143); end
        nchk++; if (WE4w !== 1'b1) begin nfail++; $display("FAIL midrst_fresh_we4w: got %b expected 1", WE4w); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int cyc;
        int t1;
        int t2;
        issue(32'd3, 32'd4, 1'b0, 1'b0);
        wait_done(cyc);
        t1 = cycle_ctr;
        nchk++; if (ResultLo !== 32'd12) begin nfail++; $display("FAIL b2b_first_lo: got %h expected %h", ResultLo, 32'd12); end
        @(posedge clk);
        #1;
        issue(32'd20, 32'd30, 1'b0, 1'b0);
        wait_done(cyc);
        t2 = cycle_ctr;
        nchk++; if (t2 - t1 !== 34) begin nfail++; $display("FAIL b2b_spacing: got %0d expected 34", t2 - t1); end
        nchk++; if (ResultLo !== 32'd600) begin nfail++; $display("FAIL b2b_second_lo: got %h expected %h", ResultLo, 32'd600); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        nchk   = 0;
        nfail  = 0;
        reset  = 1'b1;
        Start  = 1'b0;
        Long   = 1'b0;
        Signed = 1'b0;
        SrcA   = '0;
        SrcB   = '0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_long();
        test_short_hiword();
        test_zero();
        test_signed();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; product width is 2*WIDTH.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 The block SHALL have port Start, input, 1: request a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port Long, input, 1: 1 = UMULL/SMULL (64-bit write), 0 = MUL (low word only); captured with Start.
REQ-006 The block SHALL have port Signed, input, 1: 1 = signed operands; captured with Start.
REQ-007 The block SHALL have port SrcA, input, WIDTH: multiplicand; captured with Start.
REQ-008 The block SHALL have port SrcB, input, WIDTH: multiplier; captured with Start.
REQ-009 The block SHALL have port Busy, output, 1: high in RUN and DONE; the main FSM holds its state while Busy is high.
REQ-010 The block SHALL have port Done, output, 1: one-cycle pulse when results are valid.
REQ-011 The block SHALL have port ResultLo, output, WIDTH: low product word.
REQ-012 The block SHALL have port ResultHi, output, WIDTH: high product word.
REQ-013 The block SHALL have port WE4w, output, 1: second-register-write enable, high only in the Done cycle of a Long operation.

Function
REQ-014 The state machine SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE with Start=1, the block SHALL capture all inputs, clear the accumulator and iteration counter, and go to RUN on the next edge.
REQ-016 RUN SHALL perform radix-2 shift-add, one multiplier bit per cycle, LSB first, for exactly WIDTH cycles.
REQ-017 After the last RUN cycle (counter = WIDTH-1), the block SHALL go to DONE, and DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-018 Latency SHALL be WIDTH+1 cycles from the Start-sampling edge to the Done cycle (33 for WIDTH=32).
REQ-019 Start SHALL be ignored in RUN and DONE, with no restart and no queuing.
REQ-020 A new Start sampled in IDLE on the cycle after DONE SHALL be accepted, so back-to-back issue is allowed.
REQ-021 ResultLo/ResultHi SHALL update in the DONE cycle and hold until the next DONE; they SHALL NOT change during RUN.
REQ-022 The accumulator SHALL be 2*WIDTH+1 bits so that no carry is lost; the product SHALL be exact modulo 2^(2*WIDTH).
REQ-023 When Long=0, ResultHi SHALL still hold the full high word and WE4w SHALL stay 0.
REQ-024 An operand of zero SHALL still take the full latency, with no early termination.

Reset
REQ-025 When reset=1 at an edge, the block SHALL enter IDLE and set Busy=0, Done=0, WE4w=0, ResultLo=0 and ResultHi=0.
REQ-026 Reset mid-RUN SHALL abandon the operation, with no Done and no WE4w afterwards.
REQ-027 When reset and Start are high in the same cycle, reset SHALL win and Start SHALL be discarded.

Configuration
REQ-028 With macro MUL_SIGNED_EN defined and Signed=1, the block SHALL multiply the magnitudes of SrcA and SrcB and two's-complement-negate the 2*WIDTH product in DONE when the operand signs differ.
REQ-029 A magnitude of -2^(WIDTH-1) SHALL be handled as the unsigned value 2^(WIDTH-1).
REQ-030 Without MUL_SIGNED_EN, the Signed port SHALL remain present but be ignored, and all operations SHALL be unsigned.

Structure
REQ-031 Shared package mul_pkg SHALL hold the state enum (IDLE, RUN, DONE), the default WIDTH constant and the counter width $clog2(WIDTH).
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 Test: SrcA=7, SrcB=6, Long=0 -> Done at cycle 33, ResultLo=42, ResultHi=0, WE4w=0.
REQ-034 Test: unsigned 0xFFFFFFFF*0xFFFFFFFF, Long=1 -> ResultHi=0xFFFFFFFE, ResultLo=0x00000001, WE4w=1 for one cycle.
REQ-035 Test (MUL_SIGNED_EN): Signed=1, 0xFFFFFFFF*0x00000003 -> ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFFD; and 0x80000000*0x80000000 -> ResultHi=0x40000000, ResultLo=0.
REQ-036 Test: Start pulsed again at cycle 10 of RUN with different operands -> ignored, first result unchanged, single Done.
REQ-037 Test: reset asserted at RUN cycle 15 -> IDLE next edge, all outputs 0, no Done; a fresh Start then completes normally.
REQ-038 Test: back-to-back Start immediately after DONE -> second Done exactly 34 cycles after the first.
